wave_sequence_ctrl: RTL and testbench
=====================================

Name: wave_sequence_ctrl

Overview:
- Controller that schedules the ROM-based waveform generator. It steps through a programmed list of up to 4 waveform segments. Each segment has a wave select, a phase step and a duration in full periods.
- Drives the 10-bit ROM address (memory counter) and the 3-bit WAVESELECT into the ROM/mux datapath, plus a sample strobe.
- Sits between the switch/config front end and the waveform ROM, replacing manual SW-driven wave selection.

Parameters:
- PRESCALE, 4, CLK cycles per sample tick (1..255); 1 means every cycle.
- ADDR_W, 10, ROM address width; must match the ROM depth of 1024 entries.
- NSEG, 4, number of segment table entries (index width 2).

Ports:
- CLK  in  1  system clock (ring-oscillator derived).
- RST  in  1  synchronous active-high reset.
- START  in  1  begin sequence; level sampled each CLK.
- STOP  in  1  abort sequence; has priority over all other inputs.
- LOOP  in  1  1 = repeat the table after the last segment; sampled at the end of the last segment.
- WR_EN  in  1  segment table write strobe.
- WR_ADDR  in  2  segment index to write.
- WR_DATA  in  15  [14:12] wave select, [11:8] step, [7:0] period count.
- SEG_COUNT  in  3  number of active segments, 1..4.
- ADDR  out  10  ROM address.
- WAVESELECT  out  3  current wave select to the ROM/mux.
- SAMPLE_VALID  out  1  one-CLK pulse when ADDR holds a new sample.
- SEG_IDX  out  2  current segment index.
- BUSY  out  1  high in LOAD or RUN.
- DONE  out  1  one-CLK pulse when a non-looping sequence completes.

Behaviour:
- Reset values: ADDR=0, WAVESELECT=0, SAMPLE_VALID=0, SEG_IDX=0, BUSY=0, DONE=0. Table entries reset to 0, prescaler to 0, period counter to 0.
- FSM states: IDLE, LOAD, RUN.
- IDLE -> LOAD when START=1 and SEG_COUNT in 1..4.
  - START is ignored when SEG_COUNT is 0, 5, 6 or 7.
  - START is ignored in LOAD and RUN (no restart).
- LOAD lasts exactly 1 cycle:
  - latches table[SEG_IDX] into working registers;
  - WAVESELECT updates at the end of the LOAD cycle;
  - ADDR=0, prescaler=0, period counter=0;
  - next state is RUN.
- RUN sample tick: the prescaler counts 0..PRESCALE-1 and ticks on the cycle it equals PRESCALE-1, so the first tick comes PRESCALE cycles after LOAD. On each tick:
  - ADDR <= (ADDR + step) mod 1024;
  - SAMPLE_VALID=1 in the cycle after the tick (aligned with the new ADDR).
- Step 0 is treated as 1. Period count 0 is treated as 1.
- Period completion: a tick whose 11-bit sum ADDR+step >= 1024 (carry) completes one period and increments the period counter.
- Segment end: when the period counter reaches the segment's period count on a carry tick:
  - if SEG_IDX < SEG_COUNT-1: SEG_IDX++, go to LOAD;
  - else if LOOP=1: SEG_IDX=0, go to LOAD;
  - else: go to IDLE with DONE=1 for one cycle and ADDR=0; WAVESELECT holds its last value.
- STOP=1 in any state: go to IDLE next cycle, ADDR=0, SEG_IDX=0, and no DONE pulse.
  - STOP and START in the same cycle: STOP wins.
- RST mid-operation clears everything, including the table.
- WR_EN is accepted only in IDLE and writes table[WR_ADDR] in 1 cycle; WR_EN in LOAD/RUN is dropped silently.
  - WR_EN together with START in IDLE: the write commits first and LOAD reads the updated entry, since LOAD occurs in the following cycle.
- SEG_COUNT is sampled only at IDLE->LOAD and at each segment end. Mid-segment changes take effect at the next boundary.
- BUSY = (state != IDLE), registered.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'b00, LOAD=2'b01, RUN=2'b10;
  - WR_DATA field offsets;
  - wave select codes 0..7 matching the ROM mux map.
- One natural sub-module, seq_prescaler: a PRESCALE tick generator with synchronous clear. It is reused by other controllers.
- The segment table (4x15 register file) stays inline.

Test Plan:
- Single segment {wave=3, step=1, periods=1}, SEG_COUNT=1, PRESCALE=1, LOOP=0, START:
  - BUSY=1;
  - ADDR runs 1..1023 then 0;
  - 1024 SAMPLE_VALID pulses;
  - DONE pulses once; BUSY=0.
- Two segments {1,8,2} and {5,4,1}, SEG_COUNT=2, LOOP=0, START:
  - WAVESELECT=1 for 256 ticks (2 periods of 128 ticks);
  - 1-cycle LOAD, then WAVESELECT=5, SEG_IDX=1 for 256 ticks;
  - then DONE.
- LOOP=1 with the same table:
  - after segment 1 ends, SEG_IDX returns to 0 and WAVESELECT=1;
  - no DONE pulse;
  - STOP gives IDLE next cycle with ADDR=0, BUSY=0, no DONE.
- Step 0 and period count 0 entry, PRESCALE=4:
  - behaves as step 1, periods 1;
  - SAMPLE_VALID every 4 CLK.
- Non-dividing step 7:
  - ADDR wraps 1022 -> 5 (1022+7-1024) and counts one period.
- Boundary and precedence cases:
  - WR_EN during RUN: table unchanged (read back on the next run);
  - START with SEG_COUNT=0: stays IDLE;
  - START+STOP same cycle: stays IDLE;
  - RST asserted mid-RUN: all outputs at reset values the next cycle.

Source files
------------

// File: rtl/wave_sequence_ctrl_pkg.sv
// Shared definitions for the waveform sequencer: FSM encoding, segment-entry
// field layout and the wave select codes understood by the ROM mux.
package wave_sequence_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } seq_state_t;

  localparam int ENTRY_W  = 15;
  localparam int WAVE_LSB = 12;
  localparam int WAVE_W   = 3;
  localparam int STEP_LSB = 8;
  localparam int STEP_W   = 4;
  localparam int PER_LSB  = 0;
  localparam int PER_W    = 8;

  typedef enum logic [2:0] {
    WAVE_SINE    = 3'd0,
    WAVE_TRI     = 3'd1,
    WAVE_SAW     = 3'd2,
    WAVE_SQUARE  = 3'd3,
    WAVE_RSAW    = 3'd4,
    WAVE_PULSE   = 3'd5,
    WAVE_HALFSIN = 3'd6,
    WAVE_DC      = 3'd7
  } wave_sel_t;

  // A zero step would freeze the address, so it is promoted to 1.
  function automatic logic [STEP_W-1:0] eff_step(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

endpackage

// File: rtl/wave_sequence_ctrl_prescaler.sv
// Sample-tick generator: counts 0..PRESCALE-1 while enabled and pulses tick on
// the terminal count; clr restarts the count so the first tick is PRESCALE away.
module seq_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] TC = 8'(PRESCALE - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == TC);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/wave_sequence_ctrl.sv
// Segment sequencer for the ROM waveform generator: walks a 4-entry table of
// {wave, step, periods} and drives the ROM address, wave select and sample strobe.
//
// state   | meaning
// IDLE    | waiting for START; segment table writable
// LOAD    | one cycle: copy table[SEG_IDX] into working registers
// RUN     | advance ADDR by step on every prescaler tick until periods done
module wave_sequence_ctrl
  import wave_sequence_ctrl_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int ADDR_W   = 10,
  parameter int NSEG     = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    LOOP,
  input  logic                    WR_EN,
  input  logic [$clog2(NSEG)-1:0] WR_ADDR,
  input  logic [ENTRY_W-1:0]      WR_DATA,
  input  logic [2:0]              SEG_COUNT,
  output logic [ADDR_W-1:0]       ADDR,
  output logic [WAVE_W-1:0]       WAVESELECT,
  output logic                    SAMPLE_VALID,
  output logic [$clog2(NSEG)-1:0] SEG_IDX,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int         IDX_W  = $clog2(NSEG);
  localparam logic [2:0] NSEG_L = 3'(NSEG);

  seq_state_t         state;
  logic [ENTRY_W-1:0] seg_tbl [NSEG];
  logic [ENTRY_W-1:0] cur_entry;
  logic [STEP_W-1:0]  step_q;
  logic [PER_W-1:0]   per_q;
  logic [PER_W-1:0]   per_cnt;
  logic [PER_W-1:0]   per_eff;
  logic [2:0]         seg_cnt_q;
  logic [2:0]         cnt_now;
  logic [ADDR_W:0]    sum;
  logic               count_ok;
  logic               seg_end;
  logic               has_next;
  logic               tick;

  seq_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (CLK),
    .rst  (RST),
    .clr  (state != ST_RUN),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  assign cur_entry = seg_tbl[SEG_IDX];
  assign count_ok  = (SEG_COUNT != 3'd0) && (SEG_COUNT <= NSEG_L);
  // An out-of-range count at a boundary keeps the previously sampled one.
  assign cnt_now   = count_ok ? SEG_COUNT : seg_cnt_q;
  assign sum       = {1'b0, ADDR} + (ADDR_W + 1)'(eff_step(step_q));
  assign per_eff   = (per_q == '0) ? PER_W'(1) : per_q;
  assign seg_end   = sum[ADDR_W] && ((per_cnt + PER_W'(1)) == per_eff);
  assign has_next  = ({1'b0, SEG_IDX} + 3'd1) < cnt_now;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      ADDR         <= '0;
      WAVESELECT   <= WAVE_SINE;
      SAMPLE_VALID <= 1'b0;
      SEG_IDX      <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      step_q       <= '0;
      per_q        <= '0;
      per_cnt      <= '0;
      seg_cnt_q    <= '0;
      for (int i = 0; i < NSEG; i++) seg_tbl[i] <= '0;
    end else begin
      SAMPLE_VALID <= 1'b0;
      DONE         <= 1'b0;
      if (STOP) begin
        state   <= ST_IDLE;
        ADDR    <= '0;
        SEG_IDX <= '0;
        BUSY    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (WR_EN) seg_tbl[WR_ADDR] <= WR_DATA;
            if (START && count_ok) begin
              state     <= ST_LOAD;
              BUSY      <= 1'b1;
              SEG_IDX   <= '0;
              seg_cnt_q <= SEG_COUNT;
            end
          end
          ST_LOAD: begin
            WAVESELECT <= cur_entry[WAVE_LSB +: WAVE_W];
            step_q     <= cur_entry[STEP_LSB +: STEP_W];
            per_q      <= cur_entry[PER_LSB +: PER_W];
            ADDR       <= '0;
            per_cnt    <= '0;
            state      <= ST_RUN;
          end
          ST_RUN: begin
            if (tick) begin
              SAMPLE_VALID <= 1'b1;
              ADDR         <= sum[ADDR_W-1:0];
              if (seg_end) begin
                seg_cnt_q <= cnt_now;
                if (has_next) begin
                  SEG_IDX <= SEG_IDX + IDX_W'(1);
                  state   <= ST_LOAD;
                end else if (LOOP) begin
                  SEG_IDX <= '0;
                  state   <= ST_LOAD;
                end else begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  ADDR  <= '0;
                end
              end else if (sum[ADDR_W]) begin
                per_cnt <= per_cnt + PER_W'(1);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_sequence_ctrl.sv
// Bench for wave_sequence_ctrl: directed and random segment tables checked
// sample-by-sample against an arithmetic model of the sequence.
module tb_wave_sequence_ctrl;

  logic        CLK = 1'b0;
  logic        RST, START, STOP, LOOP, WR_EN;
  logic [1:0]  WR_ADDR;
  logic [14:0] WR_DATA;
  logic [2:0]  SEG_COUNT;

  logic [9:0] a1_addr, a4_addr;
  logic [2:0] a1_wave, a4_wave;
  logic [1:0] a1_seg, a4_seg;
  logic       a1_sv, a4_sv, a1_busy, a4_busy, a1_done, a4_done;

  wave_sequence_ctrl #(.PRESCALE(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .SEG_COUNT(SEG_COUNT),
    .ADDR(a1_addr), .WAVESELECT(a1_wave), .SAMPLE_VALID(a1_sv),
    .SEG_IDX(a1_seg), .BUSY(a1_busy), .DONE(a1_done));

  wave_sequence_ctrl #(.PRESCALE(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .SEG_COUNT(SEG_COUNT),
    .ADDR(a4_addr), .WAVESELECT(a4_wave), .SAMPLE_VALID(a4_sv),
    .SEG_IDX(a4_seg), .BUSY(a4_busy), .DONE(a4_done));

  always #5 CLK = ~CLK;

  logic       sel4 = 1'b0;
  logic [9:0] o_addr;
  logic [2:0] o_wave;
  logic [1:0] o_seg;
  logic       o_sv, o_busy, o_done;
  assign o_addr = sel4 ? a4_addr : a1_addr;
  assign o_wave = sel4 ? a4_wave : a1_wave;
  assign o_seg  = sel4 ? a4_seg  : a1_seg;
  assign o_sv   = sel4 ? a4_sv   : a1_sv;
  assign o_busy = sel4 ? a4_busy : a1_busy;
  assign o_done = sel4 ? a4_done : a1_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [14:0] tbl [4];
  int q_addr[$], q_wave[$], q_seg[$], q_cyc[$], q_done[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; START = 1'b0; STOP = 1'b0; LOOP = 1'b0; WR_EN = 1'b0;
    WR_ADDR = '0; WR_DATA = '0; SEG_COUNT = 3'd1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) tbl[i] = '0;
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic [14:0] data);
    WR_EN = 1'b1; WR_ADDR = idx; WR_DATA = data;
    @(negedge CLK);
    WR_EN = 1'b0;
    tbl[idx] = data;
  endtask

  // Expected sample stream: address walk by step with carries counting periods.
  // Cycle numbers count clock edges from the START edge.
  function automatic void build_model(input int p, input bit lp, input int passes, input int segc);
    int a, k, cyc, load_c, wv, st, pr, last;
    q_addr.delete(); q_wave.delete(); q_seg.delete(); q_cyc.delete(); q_done.delete();
    load_c = 1;
    for (int ps = 0; ps < passes; ps++) begin
      for (int s = 0; s < segc; s++) begin
        wv = int'(tbl[s][14:12]);
        st = int'(tbl[s][11:8]);
        pr = int'(tbl[s][7:0]);
        if (st == 0) st = 1;
        if (pr == 0) pr = 1;
        a = 0; k = 0; cyc = load_c + 1;
        while (k < pr) begin
          a += st;
          cyc += p;
          if (a >= 1024) begin a -= 1024; k++; end
          q_addr.push_back(a); q_wave.push_back(wv); q_seg.push_back(s);
          q_cyc.push_back(cyc); q_done.push_back(0);
        end
        load_c = cyc;
        last = q_addr.size() - 1;
        if (s < segc - 1) q_seg[last] = s + 1;
        else if (lp) q_seg[last] = 0;
        else begin q_addr[last] = 0; q_done[last] = 1; end
      end
    end
  endfunction

  task automatic run_seq(input bit s4, input int p, input bit lp, input int passes, input int segc,
                         input bit mid_wr, input bit wr_start, input logic [1:0] wr_idx,
                         input logic [14:0] wr_val);
    int c, budget, dn, last_wave;
    sel4 = s4; LOOP = lp; SEG_COUNT = 3'(segc);
    if (wr_start) begin
      WR_EN = 1'b1; WR_ADDR = wr_idx; WR_DATA = wr_val; tbl[wr_idx] = wr_val;
    end
    build_model(p, lp, passes, segc);
    budget = q_cyc[q_cyc.size()-1] + 16;
    last_wave = q_wave[q_wave.size()-1];
    START = 1'b1;
    @(negedge CLK);
    c = 1; START = 1'b0; WR_EN = 1'b0;
    check("busy_after_start", o_busy, 1);
    dn = 0;
    while (q_addr.size() > 0 && c < budget) begin
      @(negedge CLK);
      c++;
      if (o_done) dn++;
      if (o_sv) begin
        check("sample_addr", o_addr, q_addr.pop_front());
        check("sample_wave", o_wave, q_wave.pop_front());
        check("sample_seg",  o_seg,  q_seg.pop_front());
        check("sample_cycle", c, q_cyc.pop_front());
        check("sample_done", o_done, q_done.pop_front());
      end
      if (mid_wr) begin
        if (c == 5) begin WR_EN = 1'b1; WR_ADDR = 2'd0; WR_DATA = 15'($urandom); end
        else WR_EN = 1'b0;
      end
    end
    WR_EN = 1'b0;
    check("all_samples_seen", q_addr.size(), 0);
    if (!lp) begin
      @(negedge CLK);
      check("end_busy", o_busy, 0);
      check("end_addr", o_addr, 0);
      check("end_sv", o_sv, 0);
      check("end_wave_held", o_wave, last_wave);
      check("done_pulses", dn, 1);
    end else begin
      STOP = 1'b1;
      @(negedge CLK);
      STOP = 1'b0; LOOP = 1'b0;
      check("stop_busy", o_busy, 0);
      check("stop_addr", o_addr, 0);
      check("stop_seg", o_seg, 0);
      check("stop_done", o_done, 0);
      check("loop_no_done", dn, 0);
    end
  endtask

  initial begin
    do_reset();
    check("rst_addr", a1_addr, 0);
    check("rst_wave", a1_wave, 0);
    check("rst_sv", a1_sv, 0);
    check("rst_seg", a1_seg, 0);
    check("rst_busy", a1_busy, 0);
    check("rst_done", a1_done, 0);

    // single segment, full sweep of 1024 addresses
    write_entry(2'd0, {3'd3, 4'd1, 8'd1});
    run_seq(1'b0, 1, 1'b0, 1, 1, 1'b0, 1'b0, 2'd0, '0);

    // two segments, then a write during RUN must not stick
    do_reset();
    write_entry(2'd0, {3'd1, 4'd8, 8'd2});
    write_entry(2'd1, {3'd5, 4'd4, 8'd1});
    run_seq(1'b0, 1, 1'b0, 1, 2, 1'b0, 1'b0, 2'd0, '0);
    run_seq(1'b0, 1, 1'b0, 1, 2, 1'b1, 1'b0, 2'd0, '0);
    run_seq(1'b0, 1, 1'b0, 1, 2, 1'b0, 1'b0, 2'd0, '0);

    // looping table, stopped during the reload
    run_seq(1'b0, 1, 1'b1, 2, 2, 1'b0, 1'b0, 2'd0, '0);

    // zero step and zero periods with a prescaler of 4
    do_reset();
    write_entry(2'd0, {3'd6, 4'd0, 8'd0});
    run_seq(1'b1, 4, 1'b0, 1, 1, 1'b0, 1'b0, 2'd0, '0);

    // non-dividing step written in the same cycle as START
    do_reset();
    run_seq(1'b0, 1, 1'b0, 1, 1, 1'b0, 1'b1, 2'd0, {3'd2, 4'd7, 8'd2});

    // START ignored for invalid counts and when STOP is present
    sel4 = 1'b0;
    SEG_COUNT = 3'd0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("segcount0_idle", o_busy, 0);
    SEG_COUNT = 3'd5; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("segcount5_idle", o_busy, 0);
    SEG_COUNT = 3'd1; START = 1'b1; STOP = 1'b1;
    @(negedge CLK);
    START = 1'b0; STOP = 1'b0;
    check("start_stop_idle", o_busy, 0);
    @(negedge CLK);
    check("start_stop_sv", o_sv, 0);

    // reset in the middle of a run clears outputs and the table
    write_entry(2'd0, {3'd4, 4'd3, 8'd2});
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (20) @(negedge CLK);
    check("pre_rst_busy", o_busy, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) tbl[i] = '0;
    check("midrst_addr", a1_addr, 0);
    check("midrst_wave", a1_wave, 0);
    check("midrst_sv", a1_sv, 0);
    check("midrst_seg", a1_seg, 0);
    check("midrst_busy", a1_busy, 0);
    check("midrst_done", a1_done, 0);
    run_seq(1'b0, 1, 1'b0, 1, 1, 1'b0, 1'b0, 2'd0, '0);

    // random tables
    for (int it = 0; it < 5; it++) begin
      int segc;
      bit s4;
      do_reset();
      for (int i = 0; i < 4; i++)
        write_entry(2'(i), {3'($urandom_range(0, 7)), 4'($urandom_range(8, 15)),
                            8'($urandom_range(0, 2))});
      segc = $urandom_range(1, 4);
      s4 = 1'($urandom_range(0, 1));
      run_seq(s4, s4 ? 4 : 1, 1'b0, 1, segc, 1'b0, 1'b0, 2'd0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
